pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the pipelined CPU. It is the general successor to the fixed ID/EX latch and can be instantiated at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data payload and a control bundle under a valid/ready handshake, with flush (bubble insertion), an optional one-entry skid buffer for a registered `in_ready`, and a saturating stall counter for performance monitoring.

## Interface
- DATA_W, 64, payload width (e.g. RFRD1 and RFRD2 concatenated)
- CTRL_W, 12, control bundle width (RegDst, MemRead, ALUOp, ...)
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control value that represents a no-op; used at reset, on flush and when the stage is empty
- SKID, 1, 1 = two-entry stage with registered `in_ready`; 0 = single entry with combinational `in_ready`
- CNT_W, 16, stall counter width

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bundle
- flush  in  1  kill all held and incoming entries (branch/exception)
- out_valid  out  1  stage holds a valid instruction
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  registered payload
- out_ctrl  out  CTRL_W  registered control; equals CTRL_BUBBLE whenever out_valid=0
- stall_cnt  out  CNT_W  count of cycles with out_valid & !out_ready, saturating
- stall_clr  in  1  clears stall_cnt

## Operation
- State: main entry {m_valid, m_data, m_ctrl}, which drives the out_* ports; when SKID=1, also a skid entry {s_valid, s_data, s_ctrl}.
- Accept: in_fire = in_valid & in_ready. Drain: out_fire = out_valid & out_ready.
- SKID=1: in_ready = !rst & !s_valid (from registers only, no combinational path from out_ready).
- SKID=0: in_ready = !rst & (!m_valid | out_ready).
- Main entry update, when !m_valid or out_fire:
  - s_valid set: load from skid, clear s_valid; an in_fire in the same cycle then loads the skid.
  - else if in_fire: load from the input.
  - else: m_valid<=0 and m_ctrl<=CTRL_BUBBLE; m_data holds its value.
- When m_valid & !out_ready & in_fire (SKID=1 only): the input is written to the skid. This cannot coincide with s_valid=1, because in_ready is 0 in that case.
- Flush (priority over everything except rst): m_valid<=0, s_valid<=0, m_ctrl<=CTRL_BUBBLE, data held. An in_fire in the flush cycle is consumed and dropped. An out_fire in the flush cycle still counts as delivered.
- Ordering: entries leave strictly in arrival order. Skid contents always move to main before any newer input.
- stall_cnt:
  - increments by 1 each cycle out_valid & !out_ready and saturates at 2^CNT_W-1.
  - stall_clr is priority over increment: the value becomes 0 that cycle.
  - flush does not affect stall_cnt.

## Timing
- Reset values: out_valid=0, out_data=0, out_ctrl=CTRL_BUBBLE, stall_cnt=0, all skid state 0. in_ready=0 while rst is high and 1 in the first cycle after rst falls.
- Latency: 1 cycle from in_fire to out_valid.
- Throughput: 1 per cycle with out_ready held high, for both SKID settings.
- SKID=1 backpressure: the first stall cycle still accepts one entry into the skid. in_ready drops the following cycle. After out_ready returns, in_ready rises 1 cycle later.
- Reset mid-operation: all held entries are lost. Outputs reach reset values at the next posedge.
- Empty stage with in_valid=0: out_ctrl=CTRL_BUBBLE every cycle (bubble propagation).

## Test plan
- Reset then stream: SKID=1. Send 0x11..0x18 on consecutive cycles with out_ready=1 -> same sequence on out_data, 1 cycle later, no gaps, stall_cnt=0.
- Backpressure: drop out_ready for 3 cycles while feeding A,B,C -> A held, B captured in skid, in_ready=0 from the next cycle, C not accepted. After release: A, B, C delivered in order with no loss or duplication. stall_cnt=3.
- Flush: main=A, skid=B, in_valid with C, flush=1 -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1. A, B and C are never seen at the output.
- SKID=0: same as the backpressure scenario -> in_ready follows out_ready in the same cycle. Output is A, B, C in order.
- Saturation: CNT_W=4, stall for 20 cycles -> stall_cnt=15. stall_clr together with a stall cycle -> stall_cnt=0.
- Reset mid-stall: rst while main and skid are full -> next cycle out_valid=0, out_data=0, out_ctrl=CTRL_BUBBLE, stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: payload + control under valid/ready, with flush,
// optional one-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_reg #(
  parameter int                 DATA_W      = 64,
  parameter int                 CTRL_W      = 12,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter bit                 SKID        = 1'b1,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              in_fire;
  logic              out_fire;

  // With the skid buffer, in_ready comes from registers only so out_ready
  // never has a combinational path to the upstream stage.
  always_comb begin
    if (SKID) in_ready = !rst && !s_valid_q;
    else      in_ready = !rst && (!m_valid_q || out_ready);
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = CTRL_BUBBLE;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || out_fire) begin
      // The skid always drains into main before any newer input is taken.
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_ctrl_d  = s_ctrl_q;
        s_valid_d = 1'b0;
        if (in_fire) begin
          s_valid_d = 1'b1;
          s_data_d  = in_data;
          s_ctrl_d  = in_ctrl;
        end
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl;
      end else begin
        m_valid_d = 1'b0;
        m_ctrl_d  = CTRL_BUBBLE;
      end
    end else if (SKID && in_fire) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
      s_ctrl_d  = in_ctrl;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_clr)
      cnt_d = '0;
    else if (m_valid_q && !out_ready && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= CTRL_BUBBLE;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (SKID=1, SKID=0, SKID=1 with 4-bit counter)
// share stimulus; directed table/sequences plus random traffic against a FIFO model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [63:0] inData;
  logic [11:0] inCtrl;
  logic        flush;
  logic        outReady;
  logic        stallClr;

  logic        ov1, ir1, ov0, ir0, ov4, ir4;
  logic [63:0] od1, od0, od4;
  logic [11:0] oc1, oc0, oc4;
  logic [15:0] sc1, sc0;
  logic [3:0]  sc4;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: each instance is a FIFO of entries (depth 2 with skid, 1 without).
  logic [63:0] mData[3][2];
  logic [11:0] mCtrl[3][2];
  int          mCount[3];
  logic [63:0] mLast[3];
  int          mStall[3];

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       eir;
    int         ecnt;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ir1), .in_data(inData),
    .in_ctrl(inCtrl), .flush(flush), .out_valid(ov1), .out_ready(outReady),
    .out_data(od1), .out_ctrl(oc1), .stall_cnt(sc1), .stall_clr(stallClr)
  );

  pipe_stage_reg #(.SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ir0), .in_data(inData),
    .in_ctrl(inCtrl), .flush(flush), .out_valid(ov0), .out_ready(outReady),
    .out_data(od0), .out_ctrl(oc0), .stall_cnt(sc0), .stall_clr(stallClr)
  );

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ir4), .in_data(inData),
    .in_ctrl(inCtrl), .flush(flush), .out_valid(ov4), .out_ready(outReady),
    .out_data(od4), .out_ctrl(oc4), .stall_cnt(sc4), .stall_clr(stallClr)
  );

  function automatic logic modelReady(int k);
    if (k == 1) return !rst && ((mCount[k] == 0) || outReady);
    return !rst && (mCount[k] < 2);
  endfunction

  task automatic modelStep();
    for (int k = 0; k < 3; k++) begin
      logic inFire, outFire;
      int   maxCnt;
      maxCnt = (k == 2) ? 15 : 65535;
      if (rst) begin
        mCount[k] = 0;
        mLast[k]  = '0;
        mStall[k] = 0;
      end else begin
        inFire  = inValid && modelReady(k);
        outFire = (mCount[k] > 0) && outReady;
        if (stallClr) mStall[k] = 0;
        else if ((mCount[k] > 0) && !outReady && (mStall[k] < maxCnt)) mStall[k]++;
        if (flush) begin
          mCount[k] = 0;
        end else begin
          if (outFire) begin
            mData[k][0] = mData[k][1];
            mCtrl[k][0] = mCtrl[k][1];
            mCount[k]--;
          end
          if (inFire) begin
            mData[k][mCount[k]] = inData;
            mCtrl[k][mCount[k]] = inCtrl;
            mCount[k]++;
          end
          if (mCount[k] > 0) mLast[k] = mData[k][0];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [63:0] d, input logic [11:0] c,
                               input logic ordy, input logic fl, input logic clr);
    inValid  = iv;
    inData   = d;
    inCtrl   = c;
    outReady = ordy;
    flush    = fl;
    stallClr = clr;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic checkModel(input int k, input logic ov, input logic [63:0] od,
                            input logic [11:0] oc, input logic ir, input logic [15:0] sc);
    logic        eValid;
    logic [63:0] eData;
    logic [11:0] eCtrl;
    eValid = mCount[k] > 0;
    eData  = eValid ? mData[k][0] : mLast[k];
    eCtrl  = eValid ? mCtrl[k][0] : 12'h000;
    checkOutput($sformatf("rnd%0d_valid", k), {63'h0, ov}, {63'h0, eValid});
    checkOutput($sformatf("rnd%0d_data", k), od, eData);
    checkOutput($sformatf("rnd%0d_ctrl", k), {52'h0, oc}, {52'h0, eCtrl});
    checkOutput($sformatf("rnd%0d_ready", k), {63'h0, ir}, {63'h0, modelReady(k)});
    checkOutput($sformatf("rnd%0d_stall", k), {48'h0, sc}, 64'(mStall[k]));
  endtask

  initial begin
    // Backpressure table for the SKID=1 instance, starting with 0x18 in main.
    vecs[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h18, 1'b1, 0};
    vecs[1] = '{1'b1, 8'hA1, 1'b1, 1'b1, 8'hA1, 1'b1, 0};
    vecs[2] = '{1'b1, 8'hB2, 1'b0, 1'b1, 8'hA1, 1'b0, 1};
    vecs[3] = '{1'b1, 8'hC3, 1'b0, 1'b1, 8'hA1, 1'b0, 2};
    vecs[4] = '{1'b1, 8'hC3, 1'b0, 1'b1, 8'hA1, 1'b0, 3};
    vecs[5] = '{1'b1, 8'hC3, 1'b1, 1'b1, 8'hB2, 1'b1, 3};
    vecs[6] = '{1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 3};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hC3, 1'b1, 3};

    rst = 1'b1;
    applyStimulus(1'b0, 64'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", {63'h0, ov1}, 64'h0);
    checkOutput("rst_data", od1, 64'h0);
    checkOutput("rst_ctrl", {52'h0, oc1}, 64'h0);
    checkOutput("rst_stall", {48'h0, sc1}, 64'h0);
    checkOutput("rst_ready", {63'h0, ir1}, 64'h0);
    checkOutput("rst_ready0", {63'h0, ir0}, 64'h0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", {63'h0, ir1}, 64'h1);

    // Stream 0x11..0x18 back to back with the sink always ready.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 64'(8'h11 + i), {4'h5, 8'(8'h11 + i)}, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("stream_valid", {63'h0, ov1}, 64'h1);
      checkOutput("stream_data", od1, 64'(8'h11 + i));
      checkOutput("stream_ctrl", {52'h0, oc1}, {52'h0, 4'h5, 8'(8'h11 + i)});
      checkOutput("stream_stall", {48'h0, sc1}, 64'h0);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].iv, {56'h0, vecs[i].d}, {4'h5, vecs[i].d}, vecs[i].ordy, 1'b0, 1'b0);
      tick();
      checkOutput("tbl_valid", {63'h0, ov1}, {63'h0, vecs[i].ev});
      checkOutput("tbl_data", od1, {56'h0, vecs[i].ed});
      checkOutput("tbl_ctrl", {52'h0, oc1}, vecs[i].ev ? {52'h0, 4'h5, vecs[i].ed} : 64'h0);
      checkOutput("tbl_ready", {63'h0, ir1}, {63'h0, vecs[i].eir});
      checkOutput("tbl_stall", {48'h0, sc1}, 64'(vecs[i].ecnt));
    end

    // Flush with A in main, B in skid and C offered.
    applyStimulus(1'b1, 64'hA4, 12'h5A4, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'hB5, 12'h5B5, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("fl_pre_ready", {63'h0, ir1}, 64'h0);
    applyStimulus(1'b1, 64'hC6, 12'h5C6, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("fl_valid", {63'h0, ov1}, 64'h0);
    checkOutput("fl_ctrl", {52'h0, oc1}, 64'h0);
    checkOutput("fl_ready", {63'h0, ir1}, 64'h1);
    checkOutput("fl_data_held", od1, 64'hA4);
    checkOutput("fl_stall", {48'h0, sc1}, 64'd5);
    applyStimulus(1'b0, 64'h0, 12'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("fl_after_valid", {63'h0, ov1}, 64'h0);
    end

    // Reset while main and skid are full.
    applyStimulus(1'b1, 64'hD7, 12'h5D7, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'hE8, 12'h5E8, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b1, 64'hF9, 12'h5F9, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("mrst_valid", {63'h0, ov1}, 64'h0);
    checkOutput("mrst_data", od1, 64'h0);
    checkOutput("mrst_ctrl", {52'h0, oc1}, 64'h0);
    checkOutput("mrst_stall", {48'h0, sc1}, 64'h0);
    checkOutput("mrst_ready", {63'h0, ir1}, 64'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 64'h0, 12'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("mrst_ready_after", {63'h0, ir1}, 64'h1);
    tick();

    // SKID=0: in_ready follows out_ready in the same cycle.
    applyStimulus(1'b1, 64'hA9, 12'h5A9, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("s0_a", od0, 64'hA9);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 64'hBA, 12'h5BA, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("s0_ready_low", {63'h0, ir0}, 64'h0);
      tick();
      checkOutput("s0_hold", od0, 64'hA9);
    end
    checkOutput("s0_stall", {48'h0, sc0}, 64'd3);
    applyStimulus(1'b1, 64'hBA, 12'h5BA, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("s0_ready_high", {63'h0, ir0}, 64'h1);
    tick();
    checkOutput("s0_b", od0, 64'hBA);
    applyStimulus(1'b1, 64'hCB, 12'h5CB, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("s0_c", od0, 64'hCB);
    applyStimulus(1'b0, 64'h0, 12'h0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("s0_empty", {63'h0, ov0}, 64'h0);

    // Counter saturation on the 4-bit instance, then clear during a stall.
    applyStimulus(1'b1, 64'hDC, 12'h5DC, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("sat_value", {60'h0, sc4}, 64'd15);
    applyStimulus(1'b0, 64'h0, 12'h0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("sat_clear", {60'h0, sc4}, 64'd0);
    applyStimulus(1'b0, 64'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("sat_resume", {60'h0, sc4}, 64'd1);

    // Random traffic against the FIFO model for all three instances.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      applyStimulus($urandom_range(0, 99) < 70, {$urandom, $urandom}, 12'($urandom),
                    $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 5,
                    $urandom_range(0, 99) < 5);
      tick();
      checkModel(0, ov1, od1, oc1, ir1, sc1);
      checkModel(1, ov0, od0, oc0, ir0, sc0);
      checkModel(2, ov4, od4, oc4, ir4, {12'h0, sc4});
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
